// File: rtl/demux2_sched.sv
// Registered 1-to-2 demultiplexer functional unit: steers one input stream to out0/out1,
// either by a per-cycle select (manual) or by an alternating len0/len1 schedule (auto).
module demux2_sched #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              running,
  input  logic              run,
  input  logic [DATA_W-1:0] in0,
  input  logic              sel,
  input  logic              mode,
  input  logic [CNT_W-1:0]  len0,
  input  logic [CNT_W-1:0]  len1,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic              valid0,
  output logic              valid1
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PH0  = 2'd1,
    ST_PH1  = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_mode_q;
  logic [CNT_W-1:0]    r_len0_q;
  logic [CNT_W-1:0]    r_len1_q;
  logic [DATA_W-1:0]   r_out0;
  logic [DATA_W-1:0]   r_out1;
  logic                r_valid0;
  logic                r_valid1;

  logic                w_last0;
  logic                w_last1;
  state_t              w_start_state;

  // Phase lengths are never zero while in the matching phase, so len-1 cannot underflow there.
  assign w_last0 = (r_cnt == r_len0_q - CNT_W'(1));
  assign w_last1 = (r_cnt == r_len1_q - CNT_W'(1));

  assign w_start_state = (len0 != '0) ? ST_PH0 :
                         (len1 != '0) ? ST_PH1 : ST_IDLE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_mode_q <= 1'b0;
      r_len0_q <= '0;
      r_len1_q <= '0;
      r_out0   <= '0;
      r_out1   <= '0;
      r_valid0 <= 1'b0;
      r_valid1 <= 1'b0;
    end else begin
      r_valid0 <= 1'b0;
      r_valid1 <= 1'b0;
      if (run) begin
        // The word presented with the start pulse is dropped on purpose.
        r_mode_q <= mode;
        r_len0_q <= len0;
        r_len1_q <= len1;
        r_cnt    <= '0;
        r_state  <= w_start_state;
      end else if (running) begin
        if (!r_mode_q) begin
          if (sel) begin
            r_out1   <= in0;
            r_valid1 <= 1'b1;
          end else begin
            r_out0   <= in0;
            r_valid0 <= 1'b1;
          end
        end else begin
          case (r_state)
            ST_PH0: begin
              r_out0   <= in0;
              r_valid0 <= 1'b1;
              if (w_last0) begin
                r_cnt <= '0;
                if (r_len1_q != '0) r_state <= ST_PH1;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
            ST_PH1: begin
              r_out1   <= in0;
              r_valid1 <= 1'b1;
              if (w_last1) begin
                r_cnt <= '0;
                if (r_len0_q != '0) r_state <= ST_PH0;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
            default: begin
              r_state <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

  assign out0   = r_out0;
  assign out1   = r_out1;
  assign valid0 = r_valid0;
  assign valid1 = r_valid1;

endmodule

// File: tb/tb_demux2_sched.sv
// Directed bench for demux2_sched: a positional schedule model is compared against the
// outputs on every falling edge, plus literal checks of the captured word sequences.
module tb_demux2_sched;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          running, run, sel, mode;
  logic [DW-1:0] in0;
  logic [CW-1:0] len0, len1;
  logic [DW-1:0] out0, out1;
  logic          valid0, valid1;

  int total = 0;
  int bad   = 0;

  demux2_sched #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .running(running), .run(run), .in0(in0), .sel(sel),
    .mode(mode), .len0(len0), .len1(len1), .out0(out0), .out1(out1),
    .valid0(valid0), .valid1(valid1)
  );

  always #5 clk = ~clk;

  // Model: in auto mode the n-th routed word since run goes to out0 iff n mod (len0+len1) < len0.
  logic [DW-1:0] m_out0, m_out1;
  logic          m_v0, m_v1, m_mode;
  longint        m_l0, m_l1, m_n, m_pos;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_out0 = '0; m_out1 = '0; m_v0 = 0; m_v1 = 0;
      m_mode = 0; m_l0 = 0; m_l1 = 0; m_n = 0;
    end else begin
      m_v0 = 0; m_v1 = 0;
      if (run) begin
        m_mode = mode; m_l0 = longint'(len0); m_l1 = longint'(len1); m_n = 0;
      end else if (running) begin
        if (!m_mode) begin
          if (sel) begin m_out1 = in0; m_v1 = 1; end
          else     begin m_out0 = in0; m_v0 = 1; end
        end else if (m_l0 + m_l1 != 0) begin
          m_pos = m_n % (m_l0 + m_l1);
          if (m_pos < m_l0) begin m_out0 = in0; m_v0 = 1; end
          else              begin m_out1 = in0; m_v1 = 1; end
          m_n = m_n + 1;
        end
      end
    end
  end

  task automatic check(input string name, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Per-cycle compare plus capture of delivered words for literal checks.
  logic [DW-1:0] q0[$], q1[$];
  always @(negedge clk) begin
    check("out0",   longint'(out0),   longint'(m_out0));
    check("out1",   longint'(out1),   longint'(m_out1));
    check("valid0", longint'(valid0), longint'(m_v0));
    check("valid1", longint'(valid1), longint'(m_v1));
    if (valid0) q0.push_back(out0);
    if (valid1) q1.push_back(out1);
  end

  task automatic step(input logic r, input logic rn, input logic [DW-1:0] d, input logic s);
    run = r; running = rn; in0 = d; sel = s;
    @(posedge clk); #1;
  endtask

  task automatic start(input logic md, input int l0, input int l1);
    mode = md; len0 = CW'(l0); len1 = CW'(l1);
    step(1, 1, 32'hDEAD, 0);
    len0 = 16'hFFFF; len1 = 16'hFFFF; mode = ~md;  // scrambled config must be ignored
    run = 0;
  endtask

  task automatic check_q(input string name, input logic [DW-1:0] q[$], input int exp[]);
    check({name, "_len"}, q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < q.size(); i++)
      check(name, longint'(q[i]), longint'(exp[i]));
  endtask

  initial begin
    rst = 1; running = 0; run = 0; sel = 0; mode = 0; in0 = '0; len0 = '0; len1 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Manual routing: 10,11,12 with sel 0,1,0.
    q0.delete(); q1.delete();
    step(0, 1, 10, 0); step(0, 1, 11, 1); step(0, 1, 12, 0); step(0, 0, 77, 1);
    check_q("man_q0", q0, '{10, 12});
    check_q("man_q1", q1, '{11});
    check("man_out1_hold", longint'(out1), 11);

    // Async reset mid-stream.
    step(0, 1, 55, 1);
    #1 rst = 1;
    #1;
    check("rst_out0", longint'(out0), 0);
    check("rst_out1", longint'(out1), 0);
    check("rst_v1",   longint'(valid1), 0);
    #1 rst = 0;
    @(posedge clk); #1;
    step(0, 1, 33, 1);
    check("rst_manual", longint'(out1), 33);

    // Auto len0=2, len1=3 with words 1..10.
    start(1, 2, 3);
    q0.delete(); q1.delete();
    for (int i = 1; i <= 10; i++) step(0, 1, DW'(i), 0);
    step(0, 0, 0, 0);
    check_q("a23_q0", q0, '{1, 2, 6, 7});
    check_q("a23_q1", q1, '{3, 4, 5, 8, 9, 10});

    // Auto len 1/1 alternation.
    start(1, 1, 1);
    q0.delete(); q1.delete();
    for (int i = 20; i <= 25; i++) step(0, 1, DW'(i), 0);
    step(0, 0, 0, 0);
    check_q("a11_q0", q0, '{20, 22, 24});
    check_q("a11_q1", q1, '{21, 23, 25});

    // Auto len0=0, len1=4: everything to out1.
    start(1, 0, 4);
    q0.delete(); q1.delete();
    for (int i = 40; i <= 45; i++) step(0, 1, DW'(i), 1);
    step(0, 0, 0, 0);
    check("a04_q0_len", q0.size(), 0);
    check("a04_q1_len", q1.size(), 6);

    // Auto len0=len1=0: stays idle.
    start(1, 0, 0);
    q0.delete(); q1.delete();
    for (int i = 0; i < 5; i++) step(0, 1, DW'(i + 60), 0);
    check("a00_none", q0.size() + q1.size(), 0);

    // Auto 4/2 with a 3-cycle running stall in PH0, then run mid-PH1.
    start(1, 4, 2);
    q0.delete(); q1.delete();
    step(0, 1, 1, 0); step(0, 1, 2, 0);
    repeat (3) step(0, 0, 99, 0);
    for (int i = 3; i <= 11; i++) step(0, 1, DW'(i), 0);
    start(1, 4, 2);
    step(0, 1, 12, 0); step(0, 0, 0, 0);
    check_q("st_q0", q0, '{1, 2, 3, 4, 7, 8, 9, 10, 12});
    check_q("st_q1", q1, '{5, 6, 11});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 want=1");
    $fatal(1, "timeout");
  end
endmodule
